// File: rtl/clock_monitor_poller_if.sv
// Bus bundle for clock_monitor_poller: the CSR slave port and the measurement read master.
// The master modport is the poller's view; the slave modport is the interconnect/system view.
interface clock_monitor_poller_if;
   logic [4:0]  avs_ctrl_address;
   logic        avs_ctrl_read;
   logic        avs_ctrl_write;
   logic [31:0] avs_ctrl_writedata;
   logic [31:0] avs_ctrl_readdata;
   logic [3:0]  avm_meas_address;
   logic        avm_meas_read;
   logic        avm_meas_waitrequest;
   logic [31:0] avm_meas_readdata;
   logic        avm_meas_readdatavalid;

   modport master (
      input  avs_ctrl_address, avs_ctrl_read, avs_ctrl_write, avs_ctrl_writedata,
      output avs_ctrl_readdata,
      output avm_meas_address, avm_meas_read,
      input  avm_meas_waitrequest, avm_meas_readdata, avm_meas_readdatavalid
   );

   modport slave (
      output avs_ctrl_address, avs_ctrl_read, avs_ctrl_write, avs_ctrl_writedata,
      input  avs_ctrl_readdata,
      input  avm_meas_address, avm_meas_read,
      output avm_meas_waitrequest, avm_meas_readdata, avm_meas_readdatavalid
   );
endinterface

// File: rtl/clock_monitor_poller.sv
// Polls per-channel frequency counters over Avalon-MM and raises sticky range alarms.
// Optional macro CLOCK_MONITOR_DEBOUNCE_EN: alarm only after two consecutive out-of-range samples.
module clock_monitor_poller #(
   parameter int NUM_CH      = 8,
   parameter int CLK_FREQ    = 125000000,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                   csi_clk_clk,
   input  logic                   rsi_reset_reset,
   clock_monitor_poller_if.master bus,
   output logic                   ins_irq_irq,
   output logic                   coe_alarm_led
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK} state_t;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t        r_state, w_state_next;
   logic [2:0]    r_ch, w_ch_next;
   logic [TW-1:0] r_tout;
   logic [31:0]   r_timer;
   logic [31:0]   r_period;
   logic          r_enable, r_irq_en;
   logic [7:0]    r_alarm;
   logic          r_bus_err, r_overrun;
   logic          r_sample_ok;
   logic [31:0]   r_readdata;
   logic          r_irq, r_led;
   logic [31:0]   r_last [0:7];
   logic [31:0]   r_min  [0:7];
   logic [31:0]   r_max  [0:7];

   logic          w_tick, w_latch, w_timeout, w_check, w_oor;
   logic          w_wr, w_w1c;
   logic [7:0]    w_alarm_set;
   logic [31:0]   w_rdata;

   assign w_wr  = bus.avs_ctrl_write;
   assign w_w1c = w_wr && (bus.avs_ctrl_address == 5'd3);

   // Periods 0 and 1 both degenerate to a tick every enabled cycle.
   assign w_tick = r_enable && ((r_period <= 32'd1) || (r_timer >= r_period - 32'd1));
   assign w_oor  = (r_last[r_ch] < r_min[r_ch]) || (r_last[r_ch] > r_max[r_ch]);

   assign bus.avm_meas_read    = (r_state == S_REQ);
   assign bus.avm_meas_address = (r_state == S_REQ) ? (4'd4 + {1'b0, r_ch}) : 4'd0;
   assign bus.avs_ctrl_readdata = r_readdata;
   assign ins_irq_irq   = r_irq;
   assign coe_alarm_led = r_led;

   always_comb begin
      w_state_next = r_state;
      w_ch_next    = r_ch;
      w_latch      = 1'b0;
      w_timeout    = 1'b0;
      w_check      = 1'b0;
      case (r_state)
         S_IDLE: if (w_tick) begin
            w_state_next = S_REQ;
            w_ch_next    = 3'd0;
         end
         S_REQ: if (!bus.avm_meas_waitrequest) w_state_next = S_WAIT;
         S_WAIT: begin
            if (bus.avm_meas_readdatavalid) begin
               w_latch      = 1'b1;
               w_state_next = S_CHECK;
            end else if (r_tout == TW'(TIMEOUT_CYC - 1)) begin
               w_timeout    = 1'b1;
               w_state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            w_check = 1'b1;
            // Disabling mid-sweep lets the current channel finish, then abandons the rest.
            if ((r_ch == 3'(NUM_CH - 1)) || !r_enable) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_REQ;
               w_ch_next    = r_ch + 3'd1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

`ifdef CLOCK_MONITOR_DEBOUNCE_EN
   logic [1:0] r_miss [0:7];

   always_ff @(posedge csi_clk_clk or posedge rsi_reset_reset) begin
      if (rsi_reset_reset) begin
         for (int i = 0; i < 8; i++) r_miss[i] <= 2'd0;
      end else if (w_check) begin
         if (!r_sample_ok || !w_oor) r_miss[r_ch] <= 2'd0;
         else if (r_miss[r_ch] != 2'd3) r_miss[r_ch] <= r_miss[r_ch] + 2'd1;
      end
   end

   always_comb begin
      w_alarm_set = 8'd0;
      if (w_check && r_sample_ok && w_oor && (r_miss[r_ch] != 2'd0)) w_alarm_set[r_ch] = 1'b1;
   end
`else
   always_comb begin
      w_alarm_set = 8'd0;
      if (w_check && r_sample_ok && w_oor) w_alarm_set[r_ch] = 1'b1;
   end
`endif

   always_comb begin
      w_rdata = 32'hdeadbeef;
      case (bus.avs_ctrl_address)
         5'd0: w_rdata = 32'hc10c3010;
         5'd1: w_rdata = 32'h00010000;
         5'd2: w_rdata = {30'd0, r_irq_en, r_enable};
         5'd3: w_rdata = {22'd0, r_overrun, r_bus_err, r_alarm};
         5'd4: w_rdata = r_period;
         default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.avs_ctrl_address == 5'(5 + i))      w_rdata = r_last[i];
         if (bus.avs_ctrl_address == 5'(13 + 2 * i)) w_rdata = r_min[i];
         if (bus.avs_ctrl_address == 5'(14 + 2 * i)) w_rdata = r_max[i];
      end
   end

   always_ff @(posedge csi_clk_clk or posedge rsi_reset_reset) begin
      if (rsi_reset_reset) begin
         r_state     <= S_IDLE;
         r_ch        <= 3'd0;
         r_tout      <= '0;
         r_timer     <= 32'd0;
         r_sample_ok <= 1'b0;
         for (int i = 0; i < 8; i++) r_last[i] <= 32'd0;
      end else begin
         r_state <= w_state_next;
         r_ch    <= w_ch_next;
         r_tout  <= (r_state == S_WAIT) ? r_tout + 1'b1 : '0;
         r_timer <= (!r_enable || w_tick) ? 32'd0 : r_timer + 32'd1;
         if (w_latch) begin
            r_last[r_ch] <= bus.avm_meas_readdata;
            r_sample_ok  <= 1'b1;
         end else if (w_timeout) begin
            r_sample_ok  <= 1'b0;
         end
      end
   end

   // CSR block: set beats write-1-to-clear when both hit a status bit together.
   always_ff @(posedge csi_clk_clk or posedge rsi_reset_reset) begin
      if (rsi_reset_reset) begin
         r_enable   <= 1'b0;
         r_irq_en   <= 1'b0;
         r_period   <= 32'(CLK_FREQ);
         r_alarm    <= 8'd0;
         r_bus_err  <= 1'b0;
         r_overrun  <= 1'b0;
         r_readdata <= 32'd0;
         r_irq      <= 1'b0;
         r_led      <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_min[i] <= 32'd0;
            r_max[i] <= 32'hffffffff;
         end
      end else begin
         if (w_wr && bus.avs_ctrl_address == 5'd2) begin
            r_enable <= bus.avs_ctrl_writedata[0];
            r_irq_en <= bus.avs_ctrl_writedata[1];
         end
         if (w_wr && bus.avs_ctrl_address == 5'd4) r_period <= bus.avs_ctrl_writedata;
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr && bus.avs_ctrl_address == 5'(13 + 2 * i)) r_min[i] <= bus.avs_ctrl_writedata;
            if (w_wr && bus.avs_ctrl_address == 5'(14 + 2 * i)) r_max[i] <= bus.avs_ctrl_writedata;
         end
         r_alarm   <= (r_alarm & ~(w_w1c ? bus.avs_ctrl_writedata[7:0] : 8'd0)) | w_alarm_set;
         r_bus_err <= (r_bus_err & ~(w_w1c & bus.avs_ctrl_writedata[8])) | w_timeout;
         r_overrun <= (r_overrun & ~(w_w1c & bus.avs_ctrl_writedata[9]))
                      | (w_tick && (r_state != S_IDLE));
         if (bus.avs_ctrl_read) r_readdata <= w_rdata;
         r_irq <= r_irq_en & (|{r_overrun, r_bus_err, r_alarm});
         r_led <= |r_alarm;
      end
   end
endmodule

// File: tb/tb_clock_monitor_poller.sv
// Scoreboard bench for clock_monitor_poller: CSR read and master-address expectations are
// queued by the stimulus and popped by independent monitor / slave-model processes.
module tb_clock_monitor_poller;
   localparam int NUM_CH      = 8;
   localparam int CLK_FREQ    = 125000000;
   localparam int TIMEOUT_CYC = 256;
`ifdef CLOCK_MONITOR_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq, led;
   always #5 clk = ~clk;

   clock_monitor_poller_if bus ();

   clock_monitor_poller #(.NUM_CH(NUM_CH), .CLK_FREQ(CLK_FREQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .csi_clk_clk     (clk),
      .rsi_reset_reset (rst),
      .bus             (bus),
      .ins_irq_irq     (irq),
      .coe_alarm_led   (led)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] exp_rd_q [$];
   string       exp_rd_name [$];
   logic [3:0]  exp_addr_q [$];

   logic [31:0] resp [8];
   int          lat = 1;
   logic [3:0]  stall_addr = 4'hf;
   int          stall_rem = 0;
   bit          stall_act = 1'b0;
   logic [3:0]  drop_addr = 4'hf;
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [31:0] pdata = '0;
   int          n_acc = 0;
   int          acc_cyc [16];
   int          start_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("check %s: got %h", name, act);
      end
   endtask

   // CSR read monitor: readdata is compared one cycle after the read strobe was sampled.
   logic rd_q = 1'b0;
   always @(posedge clk) rd_q <= bus.avs_ctrl_read;
   initial forever begin
      @(negedge clk);
      if (rd_q) begin
         if (exp_rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL csr_unexpected: got %h expected no read", bus.avs_ctrl_readdata);
         end else begin
            chk(exp_rd_name.pop_front(), bus.avs_ctrl_readdata, exp_rd_q.pop_front());
         end
      end
   end

   // Counter-block slave model plus master-side monitor.
   initial begin
      bus.avm_meas_waitrequest   = 1'b0;
      bus.avm_meas_readdatavalid = 1'b0;
      bus.avm_meas_readdata      = '0;
      forever begin
         @(negedge clk);
         bus.avm_meas_readdatavalid = 1'b0;
         bus.avm_meas_waitrequest   = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               bus.avm_meas_readdatavalid = 1'b1;
               bus.avm_meas_readdata      = pdata;
               pend = 1'b0;
            end
         end
         if (stall_act)
            chk("stall_hold", {27'd0, bus.avm_meas_read, bus.avm_meas_address}, {27'd0, 1'b1, stall_addr});
         if (bus.avm_meas_read && !rst) begin
            if (!stall_act && stall_rem > 0 && bus.avm_meas_address == stall_addr) stall_act = 1'b1;
            if (stall_act && stall_rem > 0) begin
               bus.avm_meas_waitrequest = 1'b1;
               stall_rem--;
            end else begin
               stall_act = 1'b0;
               chk("no_overlap", {31'd0, pend}, 32'd0);
               if (exp_addr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL read_unexpected: got addr %h expected no read", bus.avm_meas_address);
               end else begin
                  chk("meas_addr", {28'd0, bus.avm_meas_address}, {28'd0, exp_addr_q.pop_front()});
               end
               n_acc++;
               acc_cyc[bus.avm_meas_address] = cyc;
               if (bus.avm_meas_address == 4'd4) start_q.push_back(cyc);
               if (bus.avm_meas_address == drop_addr) begin
                  drop_addr = 4'hf;
               end else begin
                  pend  = 1'b1;
                  cnt   = lat;
                  pdata = resp[3'(bus.avm_meas_address - 4'd4)];
               end
            end
         end else begin
            stall_act = 1'b0;
         end
      end
   end

   task automatic csr_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.avs_ctrl_address   = a;
      bus.avs_ctrl_writedata = d;
      bus.avs_ctrl_write     = 1'b1;
      @(negedge clk);
      bus.avs_ctrl_write     = 1'b0;
   endtask

   task automatic csr_rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      @(negedge clk);
      exp_rd_q.push_back(exp);
      exp_rd_name.push_back(name);
      bus.avs_ctrl_address = a;
      bus.avs_ctrl_read    = 1'b1;
      @(negedge clk);
      bus.avs_ctrl_read    = 1'b0;
   endtask

   task automatic sweeps(input int n, input logic [31:0] ctrl, input int budget);
      int base = n_acc;
      int k = 0;
      for (int s = 0; s < n; s++)
         for (int i = 0; i < NUM_CH; i++) exp_addr_q.push_back(4'(4 + i));
      csr_wr(5'd2, ctrl);
      while (n_acc < base + NUM_CH * n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("sweep_reads", n_acc - base, NUM_CH * n);
      csr_wr(5'd2, ctrl & ~32'd1);
      repeat (40) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.avs_ctrl_address   = '0;
      bus.avs_ctrl_read      = 1'b0;
      bus.avs_ctrl_write     = 1'b0;
      bus.avs_ctrl_writedata = '0;
      for (int i = 0; i < 8; i++) resp[i] = 32'(125000000 + i);
      repeat (3) @(negedge clk);
      chk("rst_read", {31'd0, bus.avm_meas_read}, 32'd0);
      chk("rst_addr", {28'd0, bus.avm_meas_address}, 32'd0);
      chk("rst_rdata", bus.avs_ctrl_readdata, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_led", {31'd0, led}, 32'd0);
      rst = 1'b0;

      // Register map after reset; poller stays quiet while disabled.
      csr_rd(5'd0, 32'hc10c3010, "id");
      csr_rd(5'd1, 32'h00010000, "version");
      csr_rd(5'd2, 32'd0, "ctrl_rst");
      csr_rd(5'd3, 32'd0, "status_rst");
      csr_rd(5'd4, 32'd125000000, "period_rst");
      csr_rd(5'd5, 32'd0, "last0_rst");
      csr_rd(5'd13, 32'd0, "min0_rst");
      csr_rd(5'd28, 32'hffffffff, "max7_rst");
      csr_rd(5'd29, 32'hdeadbeef, "unmapped29");
      csr_rd(5'd31, 32'hdeadbeef, "unmapped31");
      repeat (1000) @(negedge clk);
      chk("idle_no_reads", n_acc, 32'd0);

      // Periodic in-range polling.
      csr_wr(5'd4, 32'd100);
      sweeps(2, 32'd1, 1000);
      chk("sweep_spacing", start_q[1] - start_q[0], 32'd100);
      for (int i = 0; i < NUM_CH; i++) csr_rd(5'(5 + i), 32'(125000000 + i), $sformatf("last%0d", i));
      csr_rd(5'd3, 32'd0, "status_inrange");
      chk("irq_inrange", {31'd0, irq}, 32'd0);

      // ch3 above MAX; ch2 exactly at MIN==MAX stays in range.
      csr_wr(5'd19, 32'd124999000);
      csr_wr(5'd20, 32'd125001000);
      csr_wr(5'd17, 32'd125000002);
      csr_wr(5'd18, 32'd125000002);
      resp[3] = 32'd125002000;
      sweeps(2, 32'd3, 1000);
      csr_rd(5'd3, 32'h8, "status_ch3");
      csr_rd(5'd8, 32'd125002000, "last3_high");
      chk("irq_alarm", {31'd0, irq}, 32'd1);
      chk("led_alarm", {31'd0, led}, 32'd1);
      resp[3] = 32'd125000000;
      csr_wr(5'd3, 32'h8);
      repeat (3) @(negedge clk);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      chk("led_cleared", {31'd0, led}, 32'd0);
      sweeps(1, 32'd3, 1000);
      csr_rd(5'd3, 32'd0, "status_after_clear");

      // MIN > MAX self-test alarms on every sample.
      csr_wr(5'd15, 32'd200);
      csr_wr(5'd16, 32'd100);
      sweeps(2, 32'd3, 1000);
      csr_rd(5'd3, 32'h2, "status_selftest");
      csr_wr(5'd15, 32'd0);
      csr_wr(5'd16, 32'hffffffff);
      csr_wr(5'd3, 32'h3ff);
      sweeps(1, 32'd3, 1000);
      csr_rd(5'd3, 32'd0, "status_restored");

      // Stall on ch5 for 20 cycles, then never return data: bus error, sweep continues.
      resp[5] = 32'd777;
      csr_wr(5'd4, 32'd1000);
      stall_addr = 4'd9;
      stall_rem  = 20;
      drop_addr  = 4'd9;
      sweeps(1, 32'd3, 3000);
      chk("stall_gap", acc_cyc[9] - acc_cyc[8], 32'd23);
      chk("timeout_gap", acc_cyc[10] - acc_cyc[9], 32'(TIMEOUT_CYC + 2));
      csr_rd(5'd3, 32'h100, "status_buserr");
      csr_rd(5'd10, 32'd125000005, "last5_kept");
      csr_rd(5'd11, 32'd125000006, "last6_read");
      chk("irq_buserr", {31'd0, irq}, 32'd1);
      csr_wr(5'd3, 32'h3ff);

      // Ticks faster than a sweep: overrun, still one read in flight.
      resp[5] = 32'd125000005;
      csr_wr(5'd4, 32'd5);
      lat = 10;
      sweeps(1, 32'd1, 2000);
      lat = 1;
      csr_rd(5'd3, 32'h200, "status_overrun");
      chk("irq_masked", {31'd0, irq}, 32'd0);
      csr_wr(5'd3, 32'h3ff);

      // ch0 low once, in range, then low twice in a row.
      csr_wr(5'd4, 32'd100);
      csr_wr(5'd13, 32'd1000);
      resp[0] = 32'd5;
      sweeps(1, 32'd1, 1000);
      csr_rd(5'd3, DEB ? 32'd0 : 32'd1, "status_miss1");
      csr_wr(5'd3, 32'h3ff);
      resp[0] = 32'd125000000;
      sweeps(1, 32'd1, 1000);
      csr_rd(5'd3, 32'd0, "status_inrange0");
      resp[0] = 32'd5;
      sweeps(1, 32'd1, 1000);
      csr_rd(5'd3, DEB ? 32'd0 : 32'd1, "status_miss_a");
      csr_wr(5'd3, 32'h3ff);
      sweeps(1, 32'd1, 1000);
      csr_rd(5'd3, 32'd1, "status_miss_b");

      repeat (5) @(negedge clk);
      chk("addr_q_empty", exp_addr_q.size(), 32'd0);
      chk("rd_q_empty", exp_rd_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
